collision_detector: RTL



---
 rtl/flappy_pkg.sv | 29 ++
 rtl/pipe_hit_check.sv | 25 ++
 rtl/collision_detector.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// Shared geometry, scan FSM encoding and hit codes for the flappy game blocks.
// Geometry constants are 17-bit signed so sums of 16-bit positions cannot overflow.
package flappy_pkg;

  localparam logic signed [16:0] BIRD_W   = 17'sd24;
  localparam logic signed [16:0] BIRD_H   = 17'sd34;
  localparam logic signed [16:0] PIPE_W   = 17'sd52;
  localparam logic signed [16:0] GAP      = 17'sd100;
  localparam logic signed [16:0] GROUND_X = 17'sd104;
  localparam logic signed [16:0] CEIL_X   = 17'sd728;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GROUND,
    S_CEIL,
    S_PIPE1,
    S_PIPE2,
    S_PIPE3,
    S_DONE
  } scan_state_t;

  typedef enum logic [1:0] {
    HIT_NONE   = 2'd0,
    HIT_GROUND = 2'd1,
    HIT_CEIL   = 2'd2,
    HIT_PIPE   = 2'd3
  } hit_kind_t;

endpackage

// File: rtl/pipe_hit_check.sv
// Combinational bird-vs-pipe test: overlap along the scroll axis and
// bird not fully inside the opening along the flight axis.
module pipe_hit_check
  import flappy_pkg::*;
(
  input  logic signed [15:0] bx,
  input  logic signed [15:0] by,
  input  logic signed [15:0] px,
  input  logic signed [15:0] py,
  output logic               hit
);

  logic signed [16:0] bx_e, by_e, px_e, py_e;
  logic overlap, outside_gap;

  assign bx_e = {bx[15], bx};
  assign by_e = {by[15], by};
  assign px_e = {px[15], px};
  assign py_e = {py[15], py};

  assign overlap     = (by_e + BIRD_H > py_e) && (by_e < py_e + PIPE_W);
  assign outside_gap = (bx_e < px_e) || (bx_e + BIRD_W > px_e + GAP);
  assign hit         = overlap && outside_gap;

endmodule

// File: rtl/collision_detector.sv
// Fixed-latency per-frame collision scan (ground, ceiling, pipe1..3) with sticky dead flag.
// Build option: CEILING_KILL_EN enables the ceiling hit test; otherwise CEIL is a pass-through cycle.
module collision_detector
  import flappy_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               check_start,
  input  logic               enable,
  input  logic               clear,
  input  logic signed [15:0] bird_pos_x,
  input  logic signed [15:0] bird_pos_y,
  input  logic signed [15:0] pipe1_pos_x,
  input  logic signed [15:0] pipe2_pos_x,
  input  logic signed [15:0] pipe3_pos_x,
  input  logic signed [15:0] pipe1_pos_y,
  input  logic signed [15:0] pipe2_pos_y,
  input  logic signed [15:0] pipe3_pos_y,
  output logic               busy,
  output logic               done,
  output logic               dead,
  output logic [1:0]         hit_kind,
  output logic [1:0]         hit_pipe
);

  scan_state_t state_q, state_d;
  hit_kind_t   kind_q, kind_d, pend_kind_q, pend_kind_d;
  logic [1:0]  pipe_q, pipe_d, pend_pipe_q, pend_pipe_d;
  logic        busy_d, done_d, dead_d, start_ok;

  logic signed [15:0] bx_q, by_q;
  logic signed [15:0] p1x_q, p2x_q, p3x_q, p1y_q, p2y_q, p3y_q;
  logic signed [15:0] sel_px, sel_py;
  logic signed [16:0] bx_e;
  logic               pipe_hit;

  assign bx_e     = {bx_q[15], bx_q};
  assign hit_kind = kind_q;
  assign hit_pipe = pipe_q;

  // One checker shared by the three pipe states through a snapshot mux.
  always_comb begin
    sel_px = p1x_q;
    sel_py = p1y_q;
    case (state_q)
      S_PIPE2: begin sel_px = p2x_q; sel_py = p2y_q; end
      S_PIPE3: begin sel_px = p3x_q; sel_py = p3y_q; end
      default: ;
    endcase
  end

  pipe_hit_check u_pipe_hit_check (
    .bx  (bx_q),
    .by  (by_q),
    .px  (sel_px),
    .py  (sel_py),
    .hit (pipe_hit)
  );

  always_comb begin
    state_d     = state_q;
    busy_d      = busy;
    done_d      = 1'b0;
    dead_d      = dead;
    kind_d      = kind_q;
    pipe_d      = pipe_q;
    pend_kind_d = pend_kind_q;
    pend_pipe_d = pend_pipe_q;
    start_ok    = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      dead_d  = 1'b0;
      kind_d  = HIT_NONE;
      pipe_d  = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (check_start && enable) begin
            start_ok    = 1'b1;
            state_d     = S_GROUND;
            busy_d      = 1'b1;
            pend_kind_d = HIT_NONE;
            pend_pipe_d = 2'd0;
          end
        end
        S_GROUND: begin
          if (bx_e <= GROUND_X) pend_kind_d = HIT_GROUND;
          state_d = S_CEIL;
        end
        S_CEIL: begin
`ifdef CEILING_KILL_EN
          if (pend_kind_q == HIT_NONE && bx_e >= CEIL_X) pend_kind_d = HIT_CEIL;
`endif
          state_d = S_PIPE1;
        end
        S_PIPE1, S_PIPE2, S_PIPE3: begin
          if (pend_kind_q == HIT_NONE && pipe_hit) begin
            pend_kind_d = HIT_PIPE;
            pend_pipe_d = (state_q == S_PIPE1) ? 2'd1 :
                          (state_q == S_PIPE2) ? 2'd2 : 2'd3;
          end
          state_d = (state_q == S_PIPE1) ? S_PIPE2 :
                    (state_q == S_PIPE2) ? S_PIPE3 : S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Results only commit on the first death; later scans leave them alone.
          if (!dead && pend_kind_q != HIT_NONE) begin
            dead_d = 1'b1;
            kind_d = pend_kind_q;
            pipe_d = pend_pipe_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      dead        <= 1'b0;
      kind_q      <= HIT_NONE;
      pipe_q      <= 2'd0;
      pend_kind_q <= HIT_NONE;
      pend_pipe_q <= 2'd0;
      bx_q        <= '0;
      by_q        <= '0;
      p1x_q       <= '0;
      p2x_q       <= '0;
      p3x_q       <= '0;
      p1y_q       <= '0;
      p2y_q       <= '0;
      p3y_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy        <= busy_d;
      done        <= done_d;
      dead        <= dead_d;
      kind_q      <= kind_d;
      pipe_q      <= pipe_d;
      pend_kind_q <= pend_kind_d;
      pend_pipe_q <= pend_pipe_d;
      if (start_ok) begin
        bx_q  <= bird_pos_x;
        by_q  <= bird_pos_y;
        p1x_q <= pipe1_pos_x;
        p2x_q <= pipe2_pos_x;
        p3x_q <= pipe3_pos_x;
        p1y_q <= pipe1_pos_y;
        p2y_q <= pipe2_pos_y;
        p3y_q <= pipe3_pos_y;
      end
    end
  end

endmodule
